serial_xfer_ctrl: RTL and testbench
===================================

SERIAL_XFER_CTRL -- requirements
Module: serial_xfer_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, word width of the serial engine.
REQ-002 SHALL have parameter MAX_BYTES, default 16, maximum words per transfer; CW = $clog2(MAX_BYTES)+1.
REQ-003 SHALL have parameter TIMEOUT, default 4096, the maximum number of clk cycles allowed between serial word events.
REQ-004 SHALL have ports clk in 1 (clock) and rst in 1; reset rst, asynchronous, active-high; clock clk.
REQ-005 SHALL have ports in_start in 1 (transfer request pulse) and in_len in CW (number of words, sampled with in_start).
REQ-006 SHALL have ports in_abort in 1 (cancel request) and out_busy out 1 (not Idle).
REQ-007 SHALL have ports out_tx_idx out CW (index of the word to transmit) and in_tx_data in BITS (word at out_tx_idx, combinational from the caller).
REQ-008 SHALL have ports out_rx_valid out 1, out_rx_idx out CW and out_rx_data out BITS (received-word strobe, index and data).
REQ-009 SHALL have ports out_done out 1, out_aborted out 1 and out_timeout out 1 (one-cycle completion, abort and timeout pulses).
REQ-010 SHALL have the serial-engine ports out_ser_rst out 1, out_ser_enable out 1 and out_ser_parallel out BITS.
REQ-011 SHALL have the serial-engine ports in_ser_next_word in 1, in_ser_ready in 1 and in_ser_parallel in BITS.

Function
REQ-012 SHALL implement states Idle, SerRst, Xfer, Drain and Done, and SHALL register last_next = in_ser_next_word every cycle.
REQ-013 SHALL define nw_rise = in_ser_next_word & ~last_next (transmit word consumed) and nw_fall = ~in_ser_next_word & last_next (receive word complete).
REQ-014 Idle: on in_start with 1 <= in_len <= MAX_BYTES, SHALL latch len, clear tx_ctr, rx_ctr and the timer, and go to SerRst; otherwise SHALL stay in Idle.
REQ-015 SerRst: SHALL assert out_ser_rst for exactly one cycle, then go to Xfer.
REQ-016 Xfer: SHALL drive out_ser_enable=1 and out_ser_parallel=in_tx_data, with out_tx_idx=tx_ctr.
REQ-017 Xfer: on nw_rise, if tx_ctr+1 == len, SHALL go to Drain with tx_ctr unchanged; otherwise SHALL increment tx_ctr.
REQ-018 In all states except Xfer, SHALL drive out_ser_enable=0 and out_ser_parallel=0, and out_tx_idx SHALL hold tx_ctr.
REQ-019 In Xfer or Drain, on nw_fall with rx_ctr < len, SHALL register out_rx_valid=1 for one cycle, out_rx_data=in_ser_parallel and out_rx_idx=rx_ctr, then increment rx_ctr.
REQ-020 SHALL ignore an nw_fall that occurs when rx_ctr == len, with no strobe.
REQ-021 Drain: when rx_ctr == len and in_ser_ready == 1, SHALL go to Done.
REQ-022 Done: SHALL assert out_done for one cycle, then go to Idle; total out_rx_valid pulses per transfer SHALL equal len.
REQ-023 SHALL keep a timer in Xfer/Drain that clears on every nw_rise/nw_fall and otherwise increments.
REQ-024 When the timer reaches TIMEOUT-1, SHALL pulse out_timeout and out_ser_rst in the same cycle and go to Idle, without asserting out_done.
REQ-025 When in_abort is asserted in SerRst/Xfer/Drain/Done, SHALL pulse out_aborted and out_ser_rst next cycle and go to Idle, without asserting out_done.
REQ-026 SHALL ignore in_abort while in Idle.
REQ-027 Priority SHALL be in_abort > timeout > normal transition; in_start together with in_abort in Idle SHALL start the transfer.
REQ-028 SHALL ignore in_start while out_busy=1, without latching in_len.
REQ-029 SHALL drive out_busy=1 in every state except Idle.
REQ-030 SHALL perform all counter comparisons at CW bits with no wrap, since len <= MAX_BYTES < 2^CW.

Reset
REQ-031 On rst, SHALL clear state to Idle, tx_ctr, rx_ctr, len, timer and last_next to 0.
REQ-032 On rst, SHALL clear out_rx_valid, out_rx_data, out_rx_idx, out_done, out_aborted and out_timeout to 0.
REQ-033 While in reset, out_ser_rst, out_ser_enable and out_ser_parallel SHALL be 0.
REQ-034 A reset asserted mid-transfer SHALL end it silently, with no done, abort or timeout pulse.

Verification
REQ-035 SHALL cover: serial engine in loopback, in_len=4 with words ff,11,01,10 -> 4 rx strobes idx 0..3 with identical data, one out_done, out_busy low afterwards.
REQ-036 SHALL cover: in_len=0 or MAX_BYTES+1 with in_start -> stays Idle with no out_ser_rst.
REQ-037 SHALL cover: in_len=1 -> exactly one nw_rise consumed, Drain, one rx strobe, then out_done.
REQ-038 SHALL cover: in_abort during word 2 of 4 -> out_aborted and out_ser_rst pulse, no out_done, Idle.
REQ-039 SHALL cover: in_ser_next_word held low with TIMEOUT=64 -> out_timeout 64 cycles after the last event, Idle.
REQ-040 SHALL cover: in_start pulsed while busy -> ignored, len unchanged; rst mid-Xfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl: sequences a multi-word transfer through an external word-serial engine.
//
// A transfer starts with in_start and in_len = 1..MAX_BYTES. The controller resets the engine
// for one cycle and then enables it. It presents words in_tx_data[out_tx_idx] and counts
// engine handshakes:
//   rising in_ser_next_word  -> one transmit word consumed (out_tx_idx advances)
//   falling in_ser_next_word -> one receive word complete (strobed on out_rx_*)
// When every word has been sent and received and the engine reports ready, out_done pulses.
// in_abort, or TIMEOUT clk cycles with no handshake, ends the transfer early. Both pulse
// out_ser_rst together with out_aborted or out_timeout.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_start, in_len    transfer request pulse and word count (sampled together)
//   in_abort            cancel request (ignored while idle)
//   out_busy            transfer in progress
//   out_tx_idx          index of the word the caller must drive on in_tx_data
//   in_tx_data          word at out_tx_idx (combinational from the caller)
//   out_rx_valid/idx/data  one-cycle received-word strobe, its index and data
//   out_done/aborted/timeout  one-cycle end-of-transfer pulses
//   out_ser_rst, out_ser_enable, out_ser_parallel  serial engine control and transmit word
//   in_ser_next_word, in_ser_ready, in_ser_parallel  serial engine handshake, idle, rx word
module serial_xfer_ctrl #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned TIMEOUT   = 4096,
  localparam int unsigned CW       = $clog2(MAX_BYTES) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_start,
  input  logic [CW-1:0]   in_len,
  input  logic            in_abort,
  output logic            out_busy,
  output logic [CW-1:0]   out_tx_idx,
  input  logic [BITS-1:0] in_tx_data,
  output logic            out_rx_valid,
  output logic [CW-1:0]   out_rx_idx,
  output logic [BITS-1:0] out_rx_data,
  output logic            out_done,
  output logic            out_aborted,
  output logic            out_timeout,
  output logic            out_ser_rst,
  output logic            out_ser_enable,
  output logic [BITS-1:0] out_ser_parallel,
  input  logic            in_ser_next_word,
  input  logic            in_ser_ready,
  input  logic [BITS-1:0] in_ser_parallel
);

  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MaxLen = CW'(MAX_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StSerRst,
    StXfer,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     tx_ctr_q, tx_ctr_d;
  logic [CW-1:0]     rx_ctr_q, rx_ctr_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              last_next_q;
  logic              rx_valid_q, rx_valid_d;
  logic [CW-1:0]     rx_idx_q, rx_idx_d;
  logic [BITS-1:0]   rx_data_q, rx_data_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              timeout_q, timeout_d;
  logic              ser_rst_q, ser_rst_d;

  logic nw_rise, nw_fall, nw_event;
  logic active, len_ok, abort_hit, tmo_hit;
  logic [TimerW-1:0] timer_inc;

  assign nw_rise   = in_ser_next_word & ~last_next_q;
  assign nw_fall   = ~in_ser_next_word & last_next_q;
  assign nw_event  = nw_rise | nw_fall;
  assign active    = (state_q == StXfer) || (state_q == StDrain);
  assign len_ok    = (in_len != '0) && (in_len <= MaxLen);
  assign timer_inc = timer_q + TimerW'(1);
  assign abort_hit = in_abort && (state_q != StIdle);
  // The pulse is registered on the edge where the timer reaches TIMEOUT-1, so out_timeout
  // appears exactly TIMEOUT cycles after the last handshake. A handshake in the same cycle
  // proves the engine is alive and restarts the window instead.
  assign tmo_hit   = active && !nw_event && (timer_inc == TimerLast);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    tx_ctr_d   = tx_ctr_q;
    rx_ctr_d   = rx_ctr_q;
    timer_d    = timer_q;
    rx_valid_d = 1'b0;
    rx_idx_d   = rx_idx_q;
    rx_data_d  = rx_data_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    timeout_d  = 1'b0;
    ser_rst_d  = 1'b0;

    if (abort_hit) begin
      state_d   = StIdle;
      aborted_d = 1'b1;
      ser_rst_d = 1'b1;
    end else if (tmo_hit) begin
      state_d   = StIdle;
      timeout_d = 1'b1;
      ser_rst_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_start && len_ok) begin
            len_d    = in_len;
            tx_ctr_d = '0;
            rx_ctr_d = '0;
            timer_d  = '0;
            state_d  = StSerRst;
          end
        end
        StSerRst: state_d = StXfer;
        StXfer: begin
          if (nw_rise) begin
            // The last word stays indexed; only the receive side still has work to do.
            if (tx_ctr_q + CW'(1) == len_q) begin
              state_d = StDrain;
            end else begin
              tx_ctr_d = tx_ctr_q + CW'(1);
            end
          end
        end
        StDrain: begin
          if ((rx_ctr_q == len_q) && in_ser_ready) begin
            state_d = StDone;
          end
        end
        StDone: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase

      if (active) begin
        timer_d = nw_event ? '0 : timer_inc;
        // Falls beyond len are engine noise and produce no strobe.
        if (nw_fall && (rx_ctr_q < len_q)) begin
          rx_valid_d = 1'b1;
          rx_idx_d   = rx_ctr_q;
          rx_data_d  = in_ser_parallel;
          rx_ctr_d   = rx_ctr_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      tx_ctr_q    <= '0;
      rx_ctr_q    <= '0;
      timer_q     <= '0;
      last_next_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_idx_q    <= '0;
      rx_data_q   <= '0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ser_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tx_ctr_q    <= tx_ctr_d;
      rx_ctr_q    <= rx_ctr_d;
      timer_q     <= timer_d;
      last_next_q <= in_ser_next_word;
      rx_valid_q  <= rx_valid_d;
      rx_idx_q    <= rx_idx_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      timeout_q   <= timeout_d;
      ser_rst_q   <= ser_rst_d;
    end
  end

  assign out_busy         = (state_q != StIdle);
  assign out_tx_idx       = tx_ctr_q;
  assign out_rx_valid     = rx_valid_q;
  assign out_rx_idx       = rx_idx_q;
  assign out_rx_data      = rx_data_q;
  assign out_done         = done_q;
  assign out_aborted      = aborted_q;
  assign out_timeout      = timeout_q;
  // Engine reset: the start-of-transfer cycle plus the abort/timeout pulse.
  assign out_ser_rst      = (state_q == StSerRst) | ser_rst_q;
  assign out_ser_enable   = (state_q == StXfer);
  assign out_ser_parallel = out_ser_enable ? in_tx_data : '0;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Bench for serial_xfer_ctrl: a loopback serial engine model, a transaction-level scoreboard
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_serial_xfer_ctrl;
  localparam int unsigned BITS      = 8;
  localparam int unsigned MAX_BYTES = 16;
  localparam int unsigned TIMEOUT   = 64;
  localparam int unsigned CW        = $clog2(MAX_BYTES) + 1;
  localparam int EngHold = 2;
  localparam int EngGap  = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_start, in_abort;
  logic [CW-1:0]   in_len;
  logic            out_busy;
  logic [CW-1:0]   out_tx_idx;
  logic [BITS-1:0] in_tx_data;
  logic            out_rx_valid;
  logic [CW-1:0]   out_rx_idx;
  logic [BITS-1:0] out_rx_data;
  logic            out_done, out_aborted, out_timeout;
  logic            out_ser_rst, out_ser_enable;
  logic [BITS-1:0] out_ser_parallel;
  logic            in_ser_next_word, in_ser_ready;
  logic [BITS-1:0] in_ser_parallel;

  logic [BITS-1:0] tx_mem [MAX_BYTES];
  assign in_tx_data = tx_mem[out_tx_idx[CW-2:0]];

  serial_xfer_ctrl #(
    .BITS      (BITS),
    .MAX_BYTES (MAX_BYTES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_start         (in_start),
    .in_len           (in_len),
    .in_abort         (in_abort),
    .out_busy         (out_busy),
    .out_tx_idx       (out_tx_idx),
    .in_tx_data       (in_tx_data),
    .out_rx_valid     (out_rx_valid),
    .out_rx_idx       (out_rx_idx),
    .out_rx_data      (out_rx_data),
    .out_done         (out_done),
    .out_aborted      (out_aborted),
    .out_timeout      (out_timeout),
    .out_ser_rst      (out_ser_rst),
    .out_ser_enable   (out_ser_enable),
    .out_ser_parallel (out_ser_parallel),
    .in_ser_next_word (in_ser_next_word),
    .in_ser_ready     (in_ser_ready),
    .in_ser_parallel  (in_ser_parallel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loopback engine: a rising next_word takes the presented word, the fall returns it.
  int eng_ph = 0, eng_cnt = 0, eng_words = 0, eng_limit = 1000;
  logic [BITS-1:0] eng_word = '0;
  initial begin
    in_ser_next_word = 1'b0;
    in_ser_ready     = 1'b1;
    in_ser_parallel  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || out_ser_rst) begin
        in_ser_next_word = 1'b0;
        eng_ph = 0;
        eng_words = 0;
      end else begin
        case (eng_ph)
          0: if (out_ser_enable && eng_words < eng_limit) begin
            in_ser_next_word = 1'b1;
            eng_word = out_ser_parallel;
            eng_cnt = EngHold;
            eng_ph = 1;
          end
          1: if (eng_cnt > 0) eng_cnt--;
             else begin
               in_ser_next_word = 1'b0;
               in_ser_parallel = eng_word;
               eng_words++;
               eng_cnt = EngGap;
               eng_ph = 2;
             end
          default: if (eng_cnt > 0) eng_cnt--; else eng_ph = 0;
        endcase
      end
      in_ser_ready = (eng_ph == 0);
    end
  end

  // Scoreboard: expected rx order/data, tx index per handshake, end pulses and timeout delay.
  int n_done = 0, n_abort = 0, n_tmo = 0, n_rx = 0, n_rise = 0, n_ser_rst = 0, n_busy = 0;
  int cyc = 0, last_evt = 0;
  bit m_active = 0;
  int m_len = 0, m_rx_next = 0, m_tx_next = 0;
  logic prev_nw = 1'b0;
  logic [BITS-1:0] rx_log [$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_active = 0;
        prev_nw = in_ser_next_word;
        continue;
      end
      check("ser_parallel", 32'(out_ser_parallel),
            out_ser_enable ? 32'(tx_mem[out_tx_idx[CW-2:0]]) : 32'd0);
      if (out_ser_enable) check("enable_busy", 32'(out_busy), 32'd1);
      if (in_ser_next_word != prev_nw) last_evt = cyc;
      if (m_active && in_ser_next_word && !prev_nw) begin
        n_rise++;
        check("tx_idx_at_rise", 32'(out_tx_idx), 32'(m_tx_next));
        m_tx_next++;
      end
      if (out_rx_valid) begin
        n_rx++;
        rx_log.push_back(out_rx_data);
        check("rx_active", 32'(m_active), 32'd1);
        check("rx_idx", 32'(out_rx_idx), 32'(m_rx_next));
        check("rx_data", 32'(out_rx_data), 32'(tx_mem[m_rx_next[3:0]]));
        check("rx_within_len", 32'(m_rx_next < m_len), 32'd1);
        m_rx_next++;
      end
      if (out_done) begin
        n_done++;
        check("done_all_rx", 32'(m_rx_next), 32'(m_len));
        check("done_active", 32'(m_active), 32'd1);
        m_active = 0;
      end
      if (out_aborted) begin
        n_abort++;
        check("abort_ser_rst", 32'(out_ser_rst), 32'd1);
        m_active = 0;
      end
      if (out_timeout) begin
        n_tmo++;
        check("tmo_ser_rst", 32'(out_ser_rst), 32'd1);
        check("tmo_delay", 32'(cyc - last_evt), 32'(TIMEOUT));
        m_active = 0;
      end
      if (out_ser_rst) n_ser_rst++;
      if (out_busy) n_busy++;
      if (in_start && !out_busy && in_len >= 1 && in_len <= CW'(MAX_BYTES)) begin
        m_active = 1;
        m_len = int'(in_len);
        m_rx_next = 0;
        m_tx_next = 0;
      end
      prev_nw = in_ser_next_word;
    end
  end

  task automatic start(input int len);
    @(posedge clk);
    #1;
    in_start = 1'b1;
    in_len = CW'(len);
    @(posedge clk);
    #1;
    in_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(out_busy), 32'd0);
    check({tag, "_tx_idx"}, 32'(out_tx_idx), 32'd0);
    check({tag, "_rx_valid"}, 32'(out_rx_valid), 32'd0);
    check({tag, "_rx_idx"}, 32'(out_rx_idx), 32'd0);
    check({tag, "_rx_data"}, 32'(out_rx_data), 32'd0);
    check({tag, "_done"}, 32'(out_done), 32'd0);
    check({tag, "_aborted"}, 32'(out_aborted), 32'd0);
    check({tag, "_timeout"}, 32'(out_timeout), 32'd0);
    check({tag, "_ser_rst"}, 32'(out_ser_rst), 32'd0);
    check({tag, "_ser_en"}, 32'(out_ser_enable), 32'd0);
    check({tag, "_ser_par"}, 32'(out_ser_parallel), 32'd0);
  endtask

  task automatic wait_rises(input int base, input int want, input string tag);
    for (int i = 0; i < 200 && (n_rise - base) < want; i++) @(posedge clk);
    check({tag, "_rise_wait"}, 32'((n_rise - base) >= want), 32'd1);
  endtask

  int b_done, b_abort, b_tmo, b_rx, b_rise, b_srst, b_busy, b_log;
  task automatic snap();
    b_done = n_done; b_abort = n_abort; b_tmo = n_tmo; b_rx = n_rx;
    b_rise = n_rise; b_srst = n_ser_rst; b_busy = n_busy; b_log = rx_log.size();
  endtask

  logic [BITS-1:0] exp1 [4] = '{8'hff, 8'h11, 8'h01, 8'h10};

  initial begin
    rst = 1'b1;
    in_start = 1'b0;
    in_abort = 1'b0;
    in_len = '0;
    for (int i = 0; i < MAX_BYTES; i++) tx_mem[i] = 8'(i * 7 + 3);
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Four-word loopback transfer.
    for (int i = 0; i < 4; i++) tx_mem[i] = exp1[i];
    snap();
    start(4);
    idle(120);
    check("t1_done", 32'(n_done - b_done), 32'd1);
    check("t1_rx_count", 32'(n_rx - b_rx), 32'd4);
    check("t1_rises", 32'(n_rise - b_rise), 32'd4);
    for (int i = 0; i < 4; i++)
      check("t1_rx_word", 32'((rx_log.size() > b_log + i) ? rx_log[b_log + i] : 8'hxx),
            32'(exp1[i]));
    check("t1_last_idx", 32'(out_rx_idx), 32'd3);
    check("t1_last_data", 32'(out_rx_data), 32'h10);
    check("t1_busy_after", 32'(out_busy), 32'd0);
    check("t1_ser_rst", 32'(n_ser_rst - b_srst), 32'd1);
    check("t1_no_abort_tmo", 32'((n_abort - b_abort) + (n_tmo - b_tmo)), 32'd0);

    // Out-of-range lengths and an idle abort are ignored.
    snap();
    start(0);
    idle(5);
    start(MAX_BYTES + 1);
    idle(5);
    in_abort = 1'b1;
    idle(1);
    in_abort = 1'b0;
    idle(3);
    check("t2_busy_cycles", 32'(n_busy - b_busy), 32'd0);
    check("t2_ser_rst", 32'(n_ser_rst - b_srst), 32'd0);
    check("t2_abort", 32'(n_abort - b_abort), 32'd0);

    // Single-word transfer.
    tx_mem[0] = 8'h5a;
    snap();
    start(1);
    idle(60);
    check("t3_rises", 32'(n_rise - b_rise), 32'd1);
    check("t3_rx_count", 32'(n_rx - b_rx), 32'd1);
    check("t3_done", 32'(n_done - b_done), 32'd1);
    check("t3_rx_data", 32'(out_rx_data), 32'h5a);
    check("t3_rx_idx", 32'(out_rx_idx), 32'd0);

    // Abort while the second of four words is in flight.
    tx_mem[0] = 8'ha1; tx_mem[1] = 8'hb2; tx_mem[2] = 8'hc3; tx_mem[3] = 8'hd4;
    snap();
    start(4);
    wait_rises(b_rise, 2, "t4");
    @(posedge clk);
    #1;
    in_abort = 1'b1;
    @(posedge clk);
    #1;
    in_abort = 1'b0;
    check("t4_aborted", 32'(out_aborted), 32'd1);
    check("t4_ser_rst", 32'(out_ser_rst), 32'd1);
    check("t4_busy", 32'(out_busy), 32'd0);
    check("t4_done_now", 32'(out_done), 32'd0);
    idle(60);
    check("t4_done", 32'(n_done - b_done), 32'd0);
    check("t4_abort_count", 32'(n_abort - b_abort), 32'd1);
    check("t4_rx_count", 32'(n_rx - b_rx), 32'd1);
    check("t4_ser_rst_cycles", 32'(n_ser_rst - b_srst), 32'd2);

    // Engine stops after one word: timeout TIMEOUT cycles after the last handshake.
    tx_mem[0] = 8'h3c;
    eng_limit = 1;
    snap();
    start(4);
    idle(150);
    eng_limit = 1000;
    check("t5_timeout", 32'(n_tmo - b_tmo), 32'd1);
    check("t5_done", 32'(n_done - b_done), 32'd0);
    check("t5_rx_count", 32'(n_rx - b_rx), 32'd1);
    check("t5_busy", 32'(out_busy), 32'd0);
    check("t5_ser_rst_cycles", 32'(n_ser_rst - b_srst), 32'd2);

    // A start while busy is ignored and does not change the length.
    tx_mem[0] = 8'h21; tx_mem[1] = 8'h43; tx_mem[2] = 8'h65; tx_mem[3] = 8'h87;
    snap();
    start(4);
    idle(3);
    start(2);
    idle(120);
    check("t6_done", 32'(n_done - b_done), 32'd1);
    check("t6_rx_count", 32'(n_rx - b_rx), 32'd4);
    check("t6_last_data", 32'(out_rx_data), 32'h87);
    check("t6_busy", 32'(out_busy), 32'd0);

    // Reset in the middle of a transfer clears everything at once and ends it silently.
    snap();
    start(4);
    wait_rises(b_rise, 1, "t7");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("t7_midrst");
    idle(2);
    rst = 1'b0;
    idle(60);
    check("t7_pulses", 32'((n_done - b_done) + (n_abort - b_abort) + (n_tmo - b_tmo)), 32'd0);
    check("t7_busy", 32'(out_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
